// File: rtl/ace_directory_engine_pkg.sv
// Shared types, CRRESP bit positions and small helpers for the ACE coherence directory.
// Latency: none. This file holds declarations only.
// Backpressure: none. This file holds declarations only.
package ace_directory_engine_pkg;

    localparam int ADDR_WIDTH      = 32;
    localparam int DEF_NUM_MASTERS = 4;
    localparam int DEF_DIR_ENTRIES = 64;
    localparam int DEF_LINE_BYTES  = 64;
    localparam int DEF_TAG_W       = ADDR_WIDTH - $clog2(DEF_DIR_ENTRIES) - $clog2(DEF_LINE_BYTES);

    // CRRESP is {WasUnique, IsShared, PassDirty, Error, DataXfer}.
    localparam int CR_W          = 5;
    localparam int CR_DATAXFER   = 0;
    localparam int CR_ERROR      = 1;
    localparam int CR_PASSDIRTY  = 2;
    localparam int CR_ISSHARED   = 3;
    localparam int CR_WASUNIQUE  = 4;

    typedef enum logic [1:0] {
        RD_SHARED = 2'd0,
        RD_UNIQUE = 2'd1,
        CLEAN_INV = 2'd2,
        WR_BACK   = 2'd3
    } dir_op_e;

    // ACSNOOP encodings used by this block.
    typedef enum logic [3:0] {
        AC_READ_ONCE     = 4'b0000,
        AC_READ_SHARED   = 4'b0001,
        AC_READ_UNIQUE   = 4'b0111,
        AC_CLEAN_INVALID = 4'b1001
    } ace_ac_snoop_e;

    // Default-geometry directory entry; the engine builds its own for other geometries.
    typedef struct packed {
        logic [DEF_TAG_W-1:0]       tag;
        logic [DEF_NUM_MASTERS-1:0] sharers;
    } dir_entry_t;

    function automatic ace_ac_snoop_e op_to_snoop(input dir_op_e op);
        case (op)
            RD_SHARED: return AC_READ_SHARED;
            RD_UNIQUE: return AC_READ_UNIQUE;
            CLEAN_INV: return AC_CLEAN_INVALID;
            default:   return AC_READ_ONCE;
        endcase
    endfunction

    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

endpackage

// File: rtl/ace_directory_engine_dir_tag_ram.sv
// Direct-mapped directory store: flop array with a per-line valid vector.
// Latency: combinational read, write lands on the next clock edge.
// Backpressure: none. The owner must not write in the same cycle as reset.
// Ports: clk/rst (sync, active-high; clears every valid bit in one cycle),
//        rd_idx -> rd_valid/rd_entry, wr_en/wr_idx/wr_valid/wr_entry.
module ace_directory_engine_dir_tag_ram
    import ace_directory_engine_pkg::*;
#(
    parameter int  DEPTH   = 64,
    parameter int  IDX_W   = $clog2(DEPTH),
    parameter type entry_t = dir_entry_t
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_valid,
    output entry_t           rd_entry,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_valid,
    input  entry_t           wr_entry
);

    logic [DEPTH-1:0] valid_q;
    entry_t           mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_idx] <= wr_valid;
        end
    end

    // Payload needs no reset: it is only trusted behind a set valid bit.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem[wr_idx] <= wr_entry;
        end
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_entry = mem[rd_idx];

endmodule

// File: rtl/ace_directory_engine.sv
// Coherence directory: looks up sharers, back-invalidates victims, snoops peers, returns one response.
// Latency: a no-snoop request gives rsp_valid 3 cycles after the req handshake. Snoops add their handshake time.
// Backpressure: req_ready only in IDLE. Each AC/CR is held per master until accepted. rsp_* is held until rsp_ready.
// Ports: aclk/areset (sync, active-high; aborts any transaction), req_* in, ac_* out per master,
//        cr_* in per master, rsp_* out. Build option DIR_PERF_CNT_EN adds perf_req_cnt,
//        perf_snoop_cnt and perf_evict_cnt (32-bit, saturating).
module ace_directory_engine
    import ace_directory_engine_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int DIR_ENTRIES = 64,
    parameter int LINE_BYTES  = 64,
    parameter int MID_W       = $clog2(NUM_MASTERS)
) (
    input  logic                              aclk,
    input  logic                              areset,
    input  logic                              req_valid,
    output logic                              req_ready,
    input  logic [MID_W-1:0]                  req_master,
    input  logic [ADDR_WIDTH-1:0]             req_addr,
    input  dir_op_e                           req_op,
    output logic [NUM_MASTERS-1:0]            ac_valid,
    input  logic [NUM_MASTERS-1:0]            ac_ready,
    output logic [ADDR_WIDTH-1:0]             ac_addr,
    output ace_ac_snoop_e                     ac_snoop,
    input  logic [NUM_MASTERS-1:0]            cr_valid,
    output logic [NUM_MASTERS-1:0]            cr_ready,
    input  logic [NUM_MASTERS-1:0][CR_W-1:0]  cr_resp,
    output logic                              rsp_valid,
    input  logic                              rsp_ready,
    output logic [MID_W-1:0]                  rsp_master,
    output logic                              rsp_shared,
    output logic                              rsp_dirty,
    output logic [NUM_MASTERS-1:0]            rsp_data_src,
`ifdef DIR_PERF_CNT_EN
    output logic [31:0]                       perf_req_cnt,
    output logic [31:0]                       perf_snoop_cnt,
    output logic [31:0]                       perf_evict_cnt,
`endif
    output logic                              rsp_err
);

    localparam int IDX_W = $clog2(DIR_ENTRIES);
    localparam int OFF_W = $clog2(LINE_BYTES);
    localparam int TAG_W = ADDR_WIDTH - IDX_W - OFF_W;

    typedef struct packed {
        logic [TAG_W-1:0]       tag;
        logic [NUM_MASTERS-1:0] sharers;
    } entry_t;

    typedef enum logic [2:0] {
        ST_IDLE, ST_LOOKUP, ST_EVICT, ST_SNOOP, ST_UPDATE, ST_RESP
    } state_e;

    state_e state, state_n;

    logic [MID_W-1:0]       lat_master;
    logic [TAG_W-1:0]       lat_tag;
    logic [IDX_W-1:0]       lat_idx;
    dir_op_e                lat_op;
    logic                   hit_q;
    logic [NUM_MASTERS-1:0] old_q, tgt_q, ac_pend, cr_pend, shared_vec, data_src_q;
    logic                   dirty_q, err_q;
    logic [ADDR_WIDTH-1:0]  ac_addr_q;
    ace_ac_snoop_e          ac_snoop_q;

    logic                   rd_valid, wr_en, wr_valid;
    entry_t                 rd_entry, wr_entry;
    logic [NUM_MASTERS-1:0] req_bit, cr_fire, cr_is_shared, cr_pass_dirty, cr_xfer, cr_err;
    logic [NUM_MASTERS-1:0] tgt_lk, wb_sharers;
    logic                   hit, conflict, phase_done, req_fire;
    logic                   unused_inputs;

    assign unused_inputs = ^{req_addr[OFF_W-1:0], cr_resp};

    ace_directory_engine_dir_tag_ram #(
        .DEPTH   (DIR_ENTRIES),
        .IDX_W   (IDX_W),
        .entry_t (entry_t)
    ) u_tag_ram (
        .clk      (aclk),
        .rst      (areset),
        .rd_idx   (lat_idx),
        .rd_valid (rd_valid),
        .rd_entry (rd_entry),
        .wr_en    (wr_en),
        .wr_idx   (lat_idx),
        .wr_valid (wr_valid),
        .wr_entry (wr_entry)
    );

    always_comb begin
        req_bit       = '0;
        cr_is_shared  = '0;
        cr_pass_dirty = '0;
        cr_xfer       = '0;
        cr_err        = '0;
        req_bit[lat_master] = 1'b1;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            cr_is_shared[i]  = cr_resp[i][CR_ISSHARED];
            cr_pass_dirty[i] = cr_resp[i][CR_PASSDIRTY];
            cr_xfer[i]       = cr_resp[i][CR_DATAXFER];
            cr_err[i]        = cr_resp[i][CR_ERROR];
        end
    end

    assign req_fire   = req_valid && req_ready;
    assign hit        = rd_valid && (rd_entry.tag == lat_tag);
    assign conflict   = rd_valid && !hit && (lat_op == RD_SHARED || lat_op == RD_UNIQUE);
    // Peers to snoop; a miss (including the post-eviction view of a conflict) has none.
    assign tgt_lk     = (hit && lat_op != WR_BACK) ? (rd_entry.sharers & ~req_bit) : '0;
    // A CR is only taken once that master's AC has gone, so responses never overtake snoops.
    assign cr_fire    = cr_pend & ~ac_pend & cr_valid;
    assign phase_done = (ac_pend == '0) && (cr_pend == '0);
    assign wb_sharers = old_q & ~req_bit;

    always_ff @(posedge aclk) begin
        if (areset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE:   if (req_fire) state_n = ST_LOOKUP;
            ST_LOOKUP: begin
                if (conflict)            state_n = ST_EVICT;
                else if (tgt_lk != '0)   state_n = ST_SNOOP;
                else                     state_n = ST_UPDATE;
            end
            ST_EVICT:  if (phase_done) state_n = (tgt_q != '0) ? ST_SNOOP : ST_UPDATE;
            ST_SNOOP:  if (phase_done) state_n = ST_UPDATE;
            ST_UPDATE: state_n = ST_RESP;
            ST_RESP:   if (rsp_ready) state_n = ST_IDLE;
            default:   state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            lat_master <= '0;
            lat_tag    <= '0;
            lat_idx    <= '0;
            lat_op     <= RD_SHARED;
            hit_q      <= 1'b0;
            old_q      <= '0;
            tgt_q      <= '0;
            ac_pend    <= '0;
            cr_pend    <= '0;
            shared_vec <= '0;
            data_src_q <= '0;
            dirty_q    <= 1'b0;
            err_q      <= 1'b0;
            ac_addr_q  <= '0;
            ac_snoop_q <= AC_READ_ONCE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_fire) begin
                        lat_master <= req_master;
                        lat_tag    <= req_addr[ADDR_WIDTH-1 -: TAG_W];
                        lat_idx    <= req_addr[OFF_W +: IDX_W];
                        lat_op     <= req_op;
                    end
                end
                ST_LOOKUP: begin
                    hit_q      <= hit;
                    old_q      <= hit ? rd_entry.sharers : '0;
                    tgt_q      <= tgt_lk;
                    shared_vec <= '0;
                    data_src_q <= '0;
                    dirty_q    <= 1'b0;
                    err_q      <= 1'b0;
                    if (conflict) begin
                        // Victim sharers include the requester: it may hold the old line too.
                        ac_pend    <= rd_entry.sharers;
                        cr_pend    <= rd_entry.sharers;
                        ac_addr_q  <= {rd_entry.tag, lat_idx, {OFF_W{1'b0}}};
                        ac_snoop_q <= AC_CLEAN_INVALID;
                    end else if (tgt_lk != '0) begin
                        ac_pend    <= tgt_lk;
                        cr_pend    <= tgt_lk;
                        ac_addr_q  <= {lat_tag, lat_idx, {OFF_W{1'b0}}};
                        ac_snoop_q <= op_to_snoop(lat_op);
                    end
                end
                ST_EVICT, ST_SNOOP: begin
                    ac_pend <= ac_pend & ~ac_ready;
                    cr_pend <= cr_pend & ~cr_fire;
                    err_q   <= err_q | (|(cr_fire & cr_err));
                    // Victim-line responses say nothing about the requested line.
                    if (state == ST_SNOOP) begin
                        shared_vec <= shared_vec | (cr_fire & cr_is_shared);
                        data_src_q <= data_src_q | (cr_fire & cr_xfer);
                        dirty_q    <= dirty_q | (|(cr_fire & cr_pass_dirty));
                    end
                    if (state == ST_EVICT && phase_done && tgt_q != '0) begin
                        ac_pend    <= tgt_q;
                        cr_pend    <= tgt_q;
                        ac_addr_q  <= {lat_tag, lat_idx, {OFF_W{1'b0}}};
                        ac_snoop_q <= op_to_snoop(lat_op);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        wr_en    = 1'b0;
        wr_valid = 1'b0;
        wr_entry = '0;
        if (state == ST_UPDATE) begin
            wr_entry.tag = lat_tag;
            case (lat_op)
                RD_SHARED: begin
                    wr_en            = 1'b1;
                    wr_valid         = 1'b1;
                    wr_entry.sharers = (old_q & ~tgt_q) | shared_vec | req_bit;
                end
                RD_UNIQUE: begin
                    wr_en            = 1'b1;
                    wr_valid         = 1'b1;
                    wr_entry.sharers = req_bit;
                end
                CLEAN_INV: begin
                    wr_en = hit_q;
                end
                WR_BACK: begin
                    wr_en            = hit_q;
                    wr_valid         = (wb_sharers != '0);
                    wr_entry.sharers = wb_sharers;
                end
                default: ;
            endcase
        end
    end

    assign req_ready    = (state == ST_IDLE) && !areset;
    assign ac_valid     = ac_pend;
    assign ac_addr      = ac_addr_q;
    assign ac_snoop     = ac_snoop_q;
    assign cr_ready     = cr_pend & ~ac_pend;
    assign rsp_valid    = (state == ST_RESP);
    assign rsp_master   = rsp_valid ? lat_master : '0;
    assign rsp_shared   = rsp_valid && ((|shared_vec) ||
                          ((lat_op == RD_SHARED) && ((old_q & ~tgt_q & ~req_bit) != '0)));
    assign rsp_dirty    = rsp_valid && dirty_q;
    assign rsp_data_src = rsp_valid ? data_src_q : '0;
    assign rsp_err      = rsp_valid && err_q;

`ifdef DIR_PERF_CNT_EN
    always_ff @(posedge aclk) begin
        if (areset) begin
            perf_req_cnt   <= '0;
            perf_snoop_cnt <= '0;
            perf_evict_cnt <= '0;
        end else begin
            if (req_fire) begin
                perf_req_cnt <= sat_add32(perf_req_cnt, 32'd1);
            end
            perf_snoop_cnt <= sat_add32(perf_snoop_cnt, 32'($countones(ac_pend & ac_ready)));
            if (state == ST_LOOKUP && conflict) begin
                perf_evict_cnt <= sat_add32(perf_evict_cnt, 32'd1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_ace_directory_engine.sv
// Directed bench for the coherence directory engine.
// Latency: checks the 3-cycle no-snoop response latency and the 1-cycle return to req_ready.
// Backpressure: exercises out-of-order AC acceptance, CR gating and rsp holding.
module tb_ace_directory_engine;
    import ace_directory_engine_pkg::*;

    localparam int NM = 4;
    typedef logic [NM-1:0][CR_W-1:0] cr_vec_t;

    logic            aclk = 1'b0;
    logic            areset;
    logic            req_valid;
    logic            req_ready;
    logic [1:0]      req_master;
    logic [31:0]     req_addr;
    dir_op_e         req_op;
    logic [NM-1:0]   ac_valid;
    logic [NM-1:0]   ac_ready;
    logic [31:0]     ac_addr;
    ace_ac_snoop_e   ac_snoop;
    logic [NM-1:0]   cr_valid;
    logic [NM-1:0]   cr_ready;
    cr_vec_t         cr_resp;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [1:0]      rsp_master;
    logic            rsp_shared;
    logic            rsp_dirty;
    logic [NM-1:0]   rsp_data_src;
    logic            rsp_err;
`ifdef DIR_PERF_CNT_EN
    logic [31:0]     perf_req_cnt, perf_snoop_cnt, perf_evict_cnt;
`endif

    int              checks = 0;
    int              errors = 0;
    int              cyc;
    logic [NM-1:0]   seen;
    cr_vec_t         rv;

    ace_directory_engine dut (
        .aclk         (aclk),
        .areset       (areset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_master   (req_master),
        .req_addr     (req_addr),
        .req_op       (req_op),
        .ac_valid     (ac_valid),
        .ac_ready     (ac_ready),
        .ac_addr      (ac_addr),
        .ac_snoop     (ac_snoop),
        .cr_valid     (cr_valid),
        .cr_ready     (cr_ready),
        .cr_resp      (cr_resp),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_master   (rsp_master),
        .rsp_shared   (rsp_shared),
        .rsp_dirty    (rsp_dirty),
        .rsp_data_src (rsp_data_src),
`ifdef DIR_PERF_CNT_EN
        .perf_req_cnt   (perf_req_cnt),
        .perf_snoop_cnt (perf_snoop_cnt),
        .perf_evict_cnt (perf_evict_cnt),
`endif
        .rsp_err      (rsp_err)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Called on a negedge while IDLE; returns on the negedge after the handshake edge.
    task automatic do_req(input int m, input logic [31:0] addr, input dir_op_e op);
        check("req_ready_idle", 32'(req_ready), 1);
        req_valid  = 1'b1;
        req_master = 2'(m);
        req_addr   = addr;
        req_op     = op;
        @(negedge aclk);
        req_valid  = 1'b0;
    endtask

    // cyc counts cycles after the handshake cycle; seen collects any ac_valid on the way.
    task automatic wait_rsp(output int c, output logic [NM-1:0] s);
        c = 1;
        s = '0;
        while (rsp_valid !== 1'b1 && c < 64) begin
            s |= ac_valid;
            @(negedge aclk);
            c++;
        end
        check("rsp_valid_arrives", 32'(rsp_valid), 1);
    endtask

    task automatic check_rsp(input int m, input int sh, input int dy, input int src, input int er);
        check("rsp_master", 32'(rsp_master), 32'(m));
        check("rsp_shared", 32'(rsp_shared), 32'(sh));
        check("rsp_dirty", 32'(rsp_dirty), 32'(dy));
        check("rsp_data_src", 32'(rsp_data_src), 32'(src));
        check("rsp_err", 32'(rsp_err), 32'(er));
    endtask

    task automatic accept_rsp();
        rsp_ready = 1'b1;
        @(negedge aclk);
        rsp_ready = 1'b0;
        check("rsp_valid_drop", 32'(rsp_valid), 0);
        check("req_ready_after_rsp", 32'(req_ready), 1);
    endtask

    // Accepts every expected AC in one cycle, then returns all CRs together.
    task automatic snoop_all(input int vld, input int snp, input logic [31:0] addr, input cr_vec_t resp);
        check("ac_valid", 32'(ac_valid), 32'(vld));
        check("ac_snoop", 32'(ac_snoop), 32'(snp));
        check("ac_addr", ac_addr, addr);
        check("cr_ready_before_ac", 32'(cr_ready), 0);
        ac_ready = 4'(vld);
        @(negedge aclk);
        ac_ready = '0;
        check("ac_valid_clear", 32'(ac_valid), 0);
        check("cr_ready_after_ac", 32'(cr_ready), 32'(vld));
        check("ac_addr_stable", ac_addr, addr);
        cr_valid = 4'(vld);
        cr_resp  = resp;
        @(negedge aclk);
        cr_valid = '0;
        cr_resp  = '0;
        check("cr_ready_clear", 32'(cr_ready), 0);
    endtask

    initial begin
        areset     = 1'b1;
        req_valid  = 1'b0;
        req_master = '0;
        req_addr   = '0;
        req_op     = RD_SHARED;
        ac_ready   = '0;
        cr_valid   = '0;
        cr_resp    = '0;
        rsp_ready  = 1'b0;
        repeat (3) @(negedge aclk);
        check("reset_req_ready", 32'(req_ready), 0);
        check("reset_ac_valid", 32'(ac_valid), 0);
        check("reset_cr_ready", 32'(cr_ready), 0);
        check("reset_rsp_valid", 32'(rsp_valid), 0);
        areset = 1'b0;
        @(negedge aclk);

        // A: M0 RD_SHARED 0x1000 on empty directory: no snoop, 3-cycle latency.
        do_req(0, 32'h1000, RD_SHARED);
        wait_rsp(cyc, seen);
        check("A_latency", 32'(cyc), 3);
        check("A_no_ac", 32'(seen), 0);
        check_rsp(0, 0, 0, 0, 0);
        accept_rsp();

        // B: M1 RD_SHARED 0x1000: snoop M0, IsShared back; hold rsp under backpressure.
        do_req(1, 32'h1000, RD_SHARED);
        @(negedge aclk);
        rv = '0;
        rv[0] = 5'b01000;
        snoop_all('h1, AC_READ_SHARED, 32'h1000, rv);
        wait_rsp(cyc, seen);
        repeat (2) @(negedge aclk);
        check("B_rsp_held", 32'(rsp_valid), 1);
        check_rsp(1, 1, 0, 0, 0);
        accept_rsp();

        // C: M2 RD_UNIQUE 0x1024, sharers 0011; M1 takes AC first, M0 passes dirty data.
        do_req(2, 32'h1024, RD_UNIQUE);
        @(negedge aclk);
        check("C_ac_valid", 32'(ac_valid), 'h3);
        check("C_ac_snoop", 32'(ac_snoop), 32'(AC_READ_UNIQUE));
        check("C_ac_addr", ac_addr, 32'h1000);
        cr_valid = 4'b1000;
        ac_ready = 4'b0010;
        @(negedge aclk);
        check("C_ac_valid_m0_left", 32'(ac_valid), 'h1);
        check("C_cr_ready_m1_only", 32'(cr_ready), 'h2);
        ac_ready = 4'b0001;
        cr_valid = 4'b1010;
        @(negedge aclk);
        ac_ready = '0;
        check("C_ac_valid_done", 32'(ac_valid), 0);
        check("C_cr_ready_m0_only", 32'(cr_ready), 'h1);
        cr_valid = 4'b1001;
        cr_resp[0] = 5'b00101;
        @(negedge aclk);
        cr_valid = '0;
        cr_resp  = '0;
        check("C_cr_ready_clear", 32'(cr_ready), 0);
        wait_rsp(cyc, seen);
        check_rsp(2, 0, 1, 'h1, 0);
        accept_rsp();

        // D: M0 RD_SHARED 0x0000 conflicts with tag of 0x1000 held by 0100.
        do_req(0, 32'h0000, RD_SHARED);
        @(negedge aclk);
        rv = '0;
        snoop_all('h4, AC_CLEAN_INVALID, 32'h1000, rv);
        wait_rsp(cyc, seen);
        check_rsp(0, 0, 0, 0, 0);
        accept_rsp();

        // E: M2 RD_SHARED 0x0000 -> snoop M0 only (allocated sharers 0001).
        do_req(2, 32'h0000, RD_SHARED);
        @(negedge aclk);
        rv = '0;
        rv[0] = 5'b01000;
        snoop_all('h1, AC_READ_SHARED, 32'h0000, rv);
        wait_rsp(cyc, seen);
        check_rsp(2, 1, 0, 0, 0);
        accept_rsp();

        // F: M1 RD_SHARED 0x2000 evicts 0x0000 held by 0101; evict CRs feed only rsp_err.
        do_req(1, 32'h2000, RD_SHARED);
        @(negedge aclk);
        rv = '0;
        rv[0] = 5'b00010;
        rv[2] = 5'b01101;
        snoop_all('h5, AC_CLEAN_INVALID, 32'h0000, rv);
        wait_rsp(cyc, seen);
        check_rsp(1, 0, 0, 0, 1);
        accept_rsp();

        // G: M1 WR_BACK 0x2000 as the sole sharer: no snoop, entry invalidated.
        do_req(1, 32'h2000, WR_BACK);
        wait_rsp(cyc, seen);
        check("G_latency", 32'(cyc), 3);
        check("G_no_ac", 32'(seen), 0);
        check_rsp(1, 0, 0, 0, 0);
        accept_rsp();

        // H: M3 RD_SHARED 0x0000 is a clean miss (no eviction) only if G invalidated the line.
        do_req(3, 32'h0000, RD_SHARED);
        wait_rsp(cyc, seen);
        check("H_latency", 32'(cyc), 3);
        check("H_no_ac", 32'(seen), 0);
        check_rsp(3, 0, 0, 0, 0);
        accept_rsp();

        // I: M0 CLEAN_INV 0x0000 snoops M3; reset lands mid-snoop.
        do_req(0, 32'h0000, CLEAN_INV);
        @(negedge aclk);
        check("I_ac_valid", 32'(ac_valid), 'h8);
        check("I_ac_snoop", 32'(ac_snoop), 32'(AC_CLEAN_INVALID));
`ifdef DIR_PERF_CNT_EN
        check("perf_req_cnt", perf_req_cnt, 9);
        check("perf_snoop_cnt", perf_snoop_cnt, 7);
        check("perf_evict_cnt", perf_evict_cnt, 2);
`endif
        areset = 1'b1;
        @(negedge aclk);
        check("I_abort_ac_valid", 32'(ac_valid), 0);
        check("I_abort_rsp_valid", 32'(rsp_valid), 0);
        check("I_abort_cr_ready", 32'(cr_ready), 0);
        areset = 1'b0;
        @(negedge aclk);
        check("I_req_ready_after_reset", 32'(req_ready), 1);

        // J: directory must be empty after reset: no snoop of M3.
        do_req(1, 32'h0000, RD_SHARED);
        wait_rsp(cyc, seen);
        check("J_latency", 32'(cyc), 3);
        check("J_no_ac", 32'(seen), 0);
        check_rsp(1, 0, 0, 0, 0);
        accept_rsp();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
